// File: rtl/warships_pkg.sv
// warships_pkg: definitions shared by the board-side blocks of the game.
//   - cell codes stored in board_mem (2 bits per cell)
//   - click_state_t: states of the click-to-write controller
//   - address field widths of a board_mem write address {y, x}
package warships_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_SHIP  = 2'b01;
  localparam logic [1:0] CELL_HIT   = 2'b10;
  localparam logic [1:0] CELL_MISS  = 2'b11;

  localparam int ADDR_X_W = 4;
  localparam int ADDR_Y_W = 4;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    CAPTURE      = 3'd1,
    CHECK        = 3'd2,
    DIVIDE       = 3'd3,
    WRITE        = 3'd4,
    WAIT_RELEASE = 3'd5
  } click_state_t;

endpackage

// File: rtl/btn_sync_edge.sv
// btn_sync_edge: brings an asynchronous button level into the clk domain
// through two flops and produces a one-cycle pulse on its rising edge.
// Ports:
//   clk   in  : clock
//   rst_n in  : asynchronous active-low reset, clears all flops
//   btn   in  : raw button level (may be asynchronous)
//   level out : synchronized button level
//   rise  out : high for one cycle after the synchronized level goes 0->1
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic rise
);

  logic sync_1;
  logic sync_2;
  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      prev   <= 1'b0;
    end else begin
      sync_1 <= btn;
      sync_2 <= sync_1;
      prev   <= sync_2;
    end
  end

  assign level = sync_2;
  assign rise  = sync_2 & ~prev;

endmodule

// File: rtl/grid_click_ctl.sv
// grid_click_ctl: turns a left-button press inside the X_SIZE x Y_SIZE grid
// into one write of wr_value to the board memory at the clicked cell.
// The cell index is found by repeated subtraction of CELL_SIZE, so
// CELL_SIZE need not be a power of two.
// Ports:
//   clk, rst              : clock, asynchronous active-low reset
//   enable                : presses are accepted only while high (sampled in IDLE)
//   mouse_x_pos/y_pos     : pointer position, already in the clk domain
//   mouse_left            : raw left-button level
//   wr_value              : cell code to write
//   write_addr/write_data : registered write port, {cell_y, cell_x} / code
//   write_enable          : one-cycle write strobe
//   cell_x, cell_y        : last written cell
//   click_cnt             : accepted in-grid clicks, wraps at 256
//   busy                  : FSM is not in IDLE
// Write port protocol: write_enable is a pure strobe with no back-pressure;
// board_mem must accept the write in the cycle write_enable is high.
// write_addr/write_data are valid in that cycle and hold afterwards.
module grid_click_ctl
  import warships_pkg::*;
#(
  parameter int X_POS     = 100,
  parameter int Y_POS     = 200,
  parameter int CELL_SIZE = 32,
  parameter int X_SIZE    = 12,
  parameter int Y_SIZE    = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [11:0] mouse_x_pos,
  input  logic [11:0] mouse_y_pos,
  input  logic        mouse_left,
  input  logic [1:0]  wr_value,
  output logic [7:0]  write_addr,
  output logic [1:0]  write_data,
  output logic        write_enable,
  output logic [3:0]  cell_x,
  output logic [3:0]  cell_y,
  output logic [7:0]  click_cnt,
  output logic        busy
);

  localparam logic [11:0] X_ORG  = 12'(X_POS);
  localparam logic [11:0] Y_ORG  = 12'(Y_POS);
  localparam logic [11:0] STEP   = 12'(CELL_SIZE);
  localparam logic [11:0] GRID_W = 12'(X_SIZE * CELL_SIZE);
  localparam logic [11:0] GRID_H = 12'(Y_SIZE * CELL_SIZE);

  click_state_t state;
  click_state_t state_next;

  logic        btn_level;
  logic        btn_rise;

  logic [11:0] x_q;
  logic [11:0] y_q;
  logic [1:0]  val_q;
  logic [11:0] rem_x;
  logic [11:0] rem_y;
  logic [ADDR_X_W-1:0] cnt_x;
  logic [ADDR_Y_W-1:0] cnt_y;

  logic [11:0] rel_x;
  logic [11:0] rel_y;
  logic        outside;
  logic        div_done;

  btn_sync_edge u_btn (
    .clk   (clk),
    .rst_n (rst),
    .btn   (mouse_left),
    .level (btn_level),
    .rise  (btn_rise)
  );

  // The borrow terms catch points left of / above the grid; rel_x/rel_y
  // are only meaningful when those are clear.
  assign rel_x    = x_q - X_ORG;
  assign rel_y    = y_q - Y_ORG;
  assign outside  = (x_q < X_ORG) || (y_q < Y_ORG) ||
                    (rel_x >= GRID_W) || (rel_y >= GRID_H);
  assign div_done = (rem_x < STEP) && (rem_y < STEP);

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:         if (btn_rise && enable) state_next = CAPTURE;
      CAPTURE:      state_next = CHECK;
      CHECK:        state_next = outside ? WAIT_RELEASE : DIVIDE;
      DIVIDE:       if (div_done) state_next = WRITE;
      WRITE:        state_next = WAIT_RELEASE;
      WAIT_RELEASE: if (!btn_level) state_next = IDLE;
      default:      state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q          <= '0;
      y_q          <= '0;
      val_q        <= '0;
      rem_x        <= '0;
      rem_y        <= '0;
      cnt_x        <= '0;
      cnt_y        <= '0;
      write_addr   <= '0;
      write_data   <= '0;
      write_enable <= 1'b0;
      cell_x       <= '0;
      cell_y       <= '0;
      click_cnt    <= '0;
    end else begin
      unique case (state)
        CAPTURE: begin
          x_q   <= mouse_x_pos;
          y_q   <= mouse_y_pos;
          val_q <= wr_value;
        end
        CHECK: begin
          if (!outside) begin
            rem_x <= rel_x;
            rem_y <= rel_y;
            cnt_x <= '0;
            cnt_y <= '0;
          end
        end
        DIVIDE: begin
          if (rem_x >= STEP) begin
            rem_x <= rem_x - STEP;
            cnt_x <= cnt_x + 4'd1;
          end
          if (rem_y >= STEP) begin
            rem_y <= rem_y - STEP;
            cnt_y <= cnt_y + 4'd1;
          end
          // Quotients are final in this cycle: load the write port so it is
          // registered and valid for the whole WRITE cycle.
          if (div_done) begin
            write_addr   <= {cnt_y, cnt_x};
            write_data   <= val_q;
            write_enable <= 1'b1;
          end
        end
        WRITE: begin
          write_enable <= 1'b0;
          cell_x       <= cnt_x;
          cell_y       <= cnt_y;
          click_cnt    <= click_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_grid_click_ctl.sv
// tb_grid_click_ctl: scenario tasks for grid_click_ctl with a write
// scoreboard fed when an in-grid press is driven.
module tb_grid_click_ctl;
  import warships_pkg::*;

  localparam int XP = 100;
  localparam int YP = 200;
  localparam int CS = 32;
  localparam int XS = 12;
  localparam int YS = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic [11:0] mouse_x_pos = '0;
  logic [11:0] mouse_y_pos = '0;
  logic        mouse_left = 1'b0;
  logic [1:0]  wr_value = '0;
  logic [7:0]  write_addr;
  logic [1:0]  write_data;
  logic        write_enable;
  logic [3:0]  cell_x;
  logic [3:0]  cell_y;
  logic [7:0]  click_cnt;
  logic        busy;

  int          checks = 0;
  int          failures = 0;
  int          strobe_cnt = 0;
  logic [7:0]  exp_cnt = '0;
  logic [9:0]  exp_q[$];

  always #5 clk = ~clk;

  grid_click_ctl #(
    .X_POS(XP), .Y_POS(YP), .CELL_SIZE(CS), .X_SIZE(XS), .Y_SIZE(YS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .mouse_x_pos  (mouse_x_pos),
    .mouse_y_pos  (mouse_y_pos),
    .mouse_left   (mouse_left),
    .wr_value     (wr_value),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .write_enable (write_enable),
    .cell_x       (cell_x),
    .cell_y       (cell_y),
    .click_cnt    (click_cnt),
    .busy         (busy)
  );

  // Scoreboard: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst && write_enable) begin
      logic [9:0] exp_w;
      strobe_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_strobe got addr=%h data=%b, required no strobe",
                 write_addr, write_data);
      end else begin
        exp_w = exp_q.pop_front();
        if ({write_addr, write_data} !== exp_w) begin
          failures++;
          $display("FAIL sb_write got addr=%h data=%b, required addr=%h data=%b",
                   write_addr, write_data, exp_w[9:2], exp_w[1:0]);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- model ----------------
  function automatic bit in_grid(input int x, input int y);
    return (x >= XP) && (y >= YP) && (x < XP + XS * CS) && (y < YP + YS * CS);
  endfunction

  function automatic int cell_of(input int p, input int org);
    return (p - org) / CS;
  endfunction

  // ---------------- drivers ----------------
  task automatic press(input int x, input int y, input logic [1:0] v);
    @(negedge clk);
    mouse_x_pos = 12'(x);
    mouse_y_pos = 12'(y);
    wr_value    = v;
    mouse_left  = 1'b1;
  endtask

  task automatic release_btn();
    @(negedge clk);
    mouse_left = 1'b0;
  endtask

  // cyc is the cycle number (cycle 0 = first edge sampling the press)
  // in which write_enable is high, or -1 if none within budget.
  task automatic wait_strobe(input int budget, output int cyc);
    cyc = -1;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (write_enable) begin
        cyc = k + 1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic push_exp(input int x, input int y, input logic [1:0] v);
    logic [3:0] cx;
    logic [3:0] cy;
    cx = 4'(cell_of(x, XP));
    cy = 4'(cell_of(y, YP));
    exp_q.push_back({cy, cx, v});
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    #1;
    checks++;
    if ({write_addr, write_data, write_enable, cell_x, cell_y, click_cnt, busy} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got addr=%h data=%b we=%b cx=%0d cy=%0d cnt=%0d busy=%b, required all 0",
               write_addr, write_data, write_enable, cell_x, cell_y, click_cnt, busy);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    exp_cnt = '0;
  endtask

  task automatic test_click(input int x, input int y, input logic [1:0] v,
                            input int exp_cyc, input string name);
    int cyc;
    bit ok;
    push_exp(x, y, v);
    press(x, y, v);
    wait_strobe(40, cyc);
    release_btn();
    wait_idle(40, ok);
    exp_cnt++;
    checks++;
    if (cyc !== exp_cyc) begin
      failures++;
      $display("FAIL %s_strobe_cycle got %0d, required %0d", name, cyc, exp_cyc);
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_idle got busy=%b, required 0", name, busy);
    end
    checks++;
    if ({cell_y, cell_x, click_cnt} !== {4'(cell_of(y, YP)), 4'(cell_of(x, XP)), exp_cnt}) begin
      failures++;
      $display("FAIL %s_status got cx=%0d cy=%0d cnt=%0d, required cx=%0d cy=%0d cnt=%0d",
               name, cell_x, cell_y, click_cnt, cell_of(x, XP), cell_of(y, YP), exp_cnt);
    end
  endtask

  task automatic test_random_cells();
    for (int i = 0; i < 6; i++) begin
      int x;
      int y;
      int cx;
      int cy;
      x  = XP + int'($urandom_range(0, XS * CS - 1));
      y  = YP + int'($urandom_range(0, YS * CS - 1));
      cx = cell_of(x, XP);
      cy = cell_of(y, YP);
      test_click(x, y, 2'($urandom_range(0, 3)), 6 + ((cx > cy) ? cx : cy), "random");
    end
  endtask

  task automatic test_outside();
    int pts[4][2] = '{'{99, 300}, '{484, 300}, '{300, 199}, '{300, 584}};
    for (int i = 0; i < 4; i++) begin
      int s0;
      bit ok;
      s0 = strobe_cnt;
      checks++;
      if (in_grid(pts[i][0], pts[i][1])) begin
        failures++;
        $display("FAIL outside_model point %0d classified inside, required outside", i);
      end
      press(pts[i][0], pts[i][1], CELL_HIT);
      repeat (30) @(negedge clk);
      checks++;
      if (strobe_cnt - s0 !== 0) begin
        failures++;
        $display("FAIL outside_strobes point %0d got %0d, required 0", i, strobe_cnt - s0);
      end
      release_btn();
      wait_idle(10, ok);
      checks++;
      if (!ok || click_cnt !== exp_cnt) begin
        failures++;
        $display("FAIL outside_idle point %0d got busy=%b cnt=%0d, required busy=0 cnt=%0d",
                 i, busy, click_cnt, exp_cnt);
      end
    end
  endtask

  task automatic test_hold();
    int s0;
    int cyc;
    bit ok;
    s0 = strobe_cnt;
    push_exp(200, 300, CELL_SHIP);
    press(200, 300, CELL_SHIP);
    repeat (1000) @(negedge clk);
    release_btn();
    wait_idle(20, ok);
    exp_cnt++;
    push_exp(150, 250, CELL_MISS);
    press(150, 250, CELL_MISS);
    wait_strobe(40, cyc);
    release_btn();
    wait_idle(20, ok);
    exp_cnt++;
    checks++;
    if (strobe_cnt - s0 !== 2) begin
      failures++;
      $display("FAIL hold_strobes got %0d, required 2", strobe_cnt - s0);
    end
  endtask

  task automatic test_enable();
    int s0;
    int cyc;
    bit ok;
    s0 = strobe_cnt;
    enable = 1'b0;
    press(300, 300, CELL_HIT);
    repeat (30) @(negedge clk);
    release_btn();
    repeat (5) @(negedge clk);
    checks++;
    if (strobe_cnt - s0 !== 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL enable_low got strobes=%0d busy=%b, required strobes=0 busy=0",
               strobe_cnt - s0, busy);
    end
    enable = 1'b1;
    push_exp(400, 500, CELL_HIT);
    press(400, 500, CELL_HIT);
    // edges 0..3 done: the FSM is now in CHECK
    repeat (4) @(posedge clk);
    #1 enable = 1'b0;
    wait_strobe(40, cyc);
    release_btn();
    wait_idle(20, ok);
    exp_cnt++;
    enable = 1'b1;
    checks++;
    if (cyc < 0 || click_cnt !== exp_cnt) begin
      failures++;
      $display("FAIL enable_drop got strobe_cycle=%0d cnt=%0d, required strobe and cnt=%0d",
               cyc, click_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset_mid_divide();
    int s0;
    press(483, 583, CELL_HIT);
    // DIVIDE runs from cycle 5 through cycle 16 for cell (11, 11)
    repeat (8) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({busy, write_enable, click_cnt, cell_x, cell_y} !== '0) begin
      failures++;
      $display("FAIL reset_mid_divide got busy=%b we=%b cnt=%0d cx=%0d cy=%0d, required all 0",
               busy, write_enable, click_cnt, cell_x, cell_y);
    end
    mouse_left = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    exp_cnt = '0;
    s0 = strobe_cnt;
    repeat (30) @(negedge clk);
    checks++;
    if (strobe_cnt - s0 !== 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_strobe got strobes=%0d busy=%b, required 0 and 0",
               strobe_cnt - s0, busy);
    end
  endtask

  // 256 short presses (released after one cycle) wrap click_cnt back to 0.
  task automatic test_wrap();
    int s0;
    int timeouts;
    s0 = strobe_cnt;
    timeouts = 0;
    for (int i = 0; i < 256; i++) begin
      int x;
      int y;
      int cyc;
      bit ok;
      x = XP + int'($urandom_range(0, XS * CS - 1));
      y = YP + int'($urandom_range(0, YS * CS - 1));
      push_exp(x, y, 2'(i));
      press(x, y, 2'(i));
      release_btn();
      wait_strobe(40, cyc);
      wait_idle(20, ok);
      if (cyc < 0 || !ok) timeouts++;
      exp_cnt++;
    end
    checks++;
    if (timeouts !== 0) begin
      failures++;
      $display("FAIL wrap_timeouts got %0d, required 0", timeouts);
    end
    checks++;
    if (strobe_cnt - s0 !== 256) begin
      failures++;
      $display("FAIL wrap_strobes got %0d, required 256", strobe_cnt - s0);
    end
    checks++;
    if (click_cnt !== 8'd0 || click_cnt !== exp_cnt) begin
      failures++;
      $display("FAIL wrap_click_cnt got %0d, required 0", click_cnt);
    end
  endtask

  initial begin
    test_reset();
    enable = 1'b1;
    test_click(100, 200, CELL_SHIP, 6, "origin");
    test_click(483, 583, CELL_HIT, 17, "corner");
    test_random_cells();
    test_outside();
    test_hold();
    test_enable();
    test_reset_mid_divide();
    test_wrap();
    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL sb_drain got %0d pending writes, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/grid_click_ctl.md
# grid_click_ctl

Converts mouse clicks into single-cycle writes to a board memory. Sits between `MouseCtl` (pointer position and left button) and the write port of one `board_mem` instance. On each qualified left-button press inside the 12x12 grid it computes the cell index by iterative subtraction and issues one write of a caller-supplied cell code. One instance is used per board; it also reports the last clicked cell and a click counter to the main state machine and the seven-segment display.

## Interface
Parameters:
- `X_POS`, default 100: grid left edge, pixels.
- `Y_POS`, default 200: grid top edge, pixels.
- `CELL_SIZE`, default 32: cell pitch in pixels. Any value 2..63; a power of two is not required.
- `X_SIZE`, default 12: cells per row, at most 16.
- `Y_SIZE`, default 12: cells per column, at most 16.

Ports:
- `clk`  in  1: the single clock for the block.
- `rst`  in  1: reset, asynchronous, active-low.
- `enable`  in  1: clicks are accepted only while high.
- `mouse_x_pos`  in  12: pointer x, stable in the `clk` domain.
- `mouse_y_pos`  in  12: pointer y, stable in the `clk` domain.
- `mouse_left`  in  1: left button level; may be asynchronous.
- `wr_value`  in  2: cell code to write.
- `write_addr`  out  8: {cell_y[3:0], cell_x[3:0]}.
- `write_data`  out  2: cell code being written.
- `write_enable`  out  1: one-cycle write strobe.
- `cell_x`, `cell_y`  out  4 each: last valid clicked cell.
- `click_cnt`  out  8: number of accepted in-grid clicks, wraps.
- `busy`  out  1: high in any state other than IDLE.

## Operation
- `mouse_left` passes through a 2-flop synchronizer and then a rising-edge detector. Only a rising edge is acted on.
- FSM states and transitions:
  - IDLE: on a rising edge with `enable`=1, go to CAPTURE. With `enable`=0 the edge is discarded.
  - CAPTURE: latch x, y and `wr_value`, then go to CHECK.
  - CHECK: compute rel_x = x − X_POS and rel_y = y − Y_POS. A point is outside if x < X_POS, y < Y_POS, rel_x ≥ X_SIZE·CELL_SIZE, or rel_y ≥ Y_SIZE·CELL_SIZE. Outside goes to WAIT_RELEASE; inside loads remainders and clears the counters, then goes to DIVIDE.
  - DIVIDE: each cycle, every remainder that is ≥ CELL_SIZE has CELL_SIZE subtracted and its counter incremented. When both remainders are < CELL_SIZE, go to WRITE.
  - WRITE: assert `write_enable` for one cycle, update `cell_x`, `cell_y` and `click_cnt`, then go to WAIT_RELEASE.
  - WAIT_RELEASE: return to IDLE once the synchronized button reads 0.
- Edges arriving outside IDLE are ignored. Holding the button produces exactly one write.
- `enable` is sampled only in IDLE. Dropping it mid-operation does not abort the operation.
- Arithmetic width: 12-bit unsigned with a borrow check; no wrap. Counters are 4 bits.
- `click_cnt` wraps from 255 to 0.
- Reset forces the FSM to IDLE and clears every output and the synchronizer. It takes effect immediately, including mid-DIVIDE or during WRITE.

## Timing
- Let cycle 0 be the first `clk` edge that samples `mouse_left`=1. Then:
  - The edge is detected in cycle 2.
  - CAPTURE occupies cycle 3.
  - CHECK occupies cycle 4.
  - DIVIDE lasts max(cx, cy)+1 cycles.
  - `write_enable` is high in cycle 6+max(cx, cy).
- Worst case, cell (11, 11): `write_enable` in cycle 17.
- `write_addr` and `write_data` are registered and valid in the same cycle as `write_enable`. They hold their values afterwards.
- `cell_x`, `cell_y` and `click_cnt` update on the clock edge that ends WRITE.
- Reset values: every output is 0 and `busy` is 0.
- A press released before cycle 2 is still acted on. It is a single event.

## Structure
- Shared package `warships_pkg` holds:
  - the cell codes: CELL_EMPTY=2'b00, CELL_SHIP=2'b01, CELL_HIT=2'b10, CELL_MISS=2'b11;
  - the `click_state_t` enum {IDLE, CAPTURE, CHECK, DIVIDE, WRITE, WAIT_RELEASE};
  - the address field widths (4/4).
- One sub-module, `btn_sync_edge`: 2-flop synchronizer plus rising-edge pulse, same clock and reset. It is reusable for the board buttons.

## Test plan
- Press at (100, 200), `wr_value`=01 → `write_addr`=8'h00, `write_data`=01, a single strobe in cycle 6, `click_cnt`=1.
- Press at (483, 583) with defaults → cell (11, 11), `write_addr`=8'hBB, strobe in cycle 17.
- Press at (99, 300), then at (484, 300) → no strobe on either, `click_cnt` unchanged, FSM back in IDLE after release.
- Hold the button for 1000 cycles, then release, then press again → exactly two strobes in total.
- Press with `enable`=0 → no write. Press with `enable`=1, then deassert it in CHECK → the write still occurs.
- Assert `rst` low during DIVIDE → `busy`, `write_enable`, `click_cnt` and `cell_x`/`cell_y` are 0 immediately, and no strobe follows. Also 256 valid clicks → `click_cnt` reads 0.
